// File: rtl/codec_i2s_tx.sv
// I2S playback serializer and sample-rate timing master: divides clk into SCLK/LRCLK,
// shifts the latched stereo pair out MSB first, and strobes 'valid' to request the next pair.
module codec_i2s_tx #(
    parameter int SCLK_DIV = 8,
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mute,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              valid
);

    localparam int DIV_BW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_BW = $clog2(2 * SLOT_W);

    localparam logic [DIV_BW-1:0] DIV_LAST  = DIV_BW'(SCLK_DIV - 1);
    localparam logic [DIV_BW-1:0] DIV_ONE   = DIV_BW'(1);
    localparam logic [BIT_BW-1:0] BIT_LAST  = BIT_BW'(2 * SLOT_W - 1);
    localparam logic [BIT_BW-1:0] BIT_ONE   = BIT_BW'(1);
    localparam logic [BIT_BW-1:0] BIT_ZERO  = BIT_BW'(0);
    localparam logic [BIT_BW-1:0] SLOT_R    = BIT_BW'(SLOT_W);
    localparam logic [BIT_BW-1:0] POS_FIRST = BIT_BW'(1);
    localparam logic [BIT_BW-1:0] POS_LAST  = BIT_BW'(DATA_W);

    logic [DIV_BW-1:0] div_cnt_r;
    logic              sclk_r;
    logic [BIT_BW-1:0] bit_cnt_r;
    logic              lrclk_r;
    logic              sdata_r;
    logic              valid_r;
    logic [DATA_W-1:0] shadow_l_r;
    logic [DATA_W-1:0] shadow_r_r;
    logic              mute_q_r;
    logic [DATA_W-1:0] shift_r;

    logic              div_wrap_s;
    logic              fall_s;
    logic [BIT_BW-1:0] bit_nxt_s;
    logic              right_slot_s;
    logic [BIT_BW-1:0] pos_s;
    logic [DATA_W-1:0] word_s;

    // Next slot position and the word feeding it; shadows are already latched when n=1 is reached.
    always_comb begin
        div_wrap_s = (div_cnt_r == DIV_LAST);
        fall_s     = div_wrap_s && sclk_r;
        if (bit_cnt_r == BIT_LAST) begin
            bit_nxt_s = BIT_ZERO;
        end else begin
            bit_nxt_s = bit_cnt_r + BIT_ONE;
        end
        right_slot_s = (bit_nxt_s >= SLOT_R);
        if (right_slot_s) begin
            pos_s = bit_nxt_s - SLOT_R;
        end else begin
            pos_s = bit_nxt_s;
        end
        if (mute_q_r) begin
            word_s = '0;
        end else if (right_slot_s) begin
            word_s = shadow_r_r;
        end else begin
            word_s = shadow_l_r;
        end
    end

    // Clock divider, frame counter, sample capture and serializer; en=0 mirrors reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r  <= '0;
            sclk_r     <= 1'b0;
            bit_cnt_r  <= BIT_LAST;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            valid_r    <= 1'b0;
            shadow_l_r <= '0;
            shadow_r_r <= '0;
            mute_q_r   <= 1'b0;
            shift_r    <= '0;
        end else if (!en) begin
            div_cnt_r  <= '0;
            sclk_r     <= 1'b0;
            bit_cnt_r  <= BIT_LAST;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            valid_r    <= 1'b0;
            shadow_l_r <= '0;
            shadow_r_r <= '0;
            mute_q_r   <= 1'b0;
            shift_r    <= '0;
        end else begin
            valid_r <= 1'b0;
            if (div_wrap_s) begin
                div_cnt_r <= '0;
                sclk_r    <= ~sclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
            if (fall_s) begin
                bit_cnt_r <= bit_nxt_s;
                lrclk_r   <= right_slot_s;
                valid_r   <= (bit_nxt_s == SLOT_R);
                if (bit_nxt_s == BIT_ZERO) begin
                    shadow_l_r <= left_in;
                    shadow_r_r <= right_in;
                    mute_q_r   <= mute;
                end
                // n=0 is the I2S delay bit; n=1 loads the word, later bits drain the shifter.
                if (pos_s == POS_FIRST) begin
                    sdata_r <= word_s[DATA_W-1];
                    shift_r <= {word_s[DATA_W-2:0], 1'b0};
                end else if ((pos_s != BIT_ZERO) && (pos_s <= POS_LAST)) begin
                    sdata_r <= shift_r[DATA_W-1];
                    shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                end else begin
                    sdata_r <= 1'b0;
                end
            end
        end
    end

    assign sclk  = sclk_r;
    assign lrclk = lrclk_r;
    assign sdata = sdata_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_codec_i2s_tx.sv
// Scoreboard bench for codec_i2s_tx: stimulus queues expected slot words, a monitor
// deserializes sdata on sclk falls and checks words, padding and valid timing.
module tb_codec_i2s_tx;

    localparam int SCLK_DIV   = 2;
    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 32;
    localparam int FRAME_CLKS = 4 * SLOT_W * SCLK_DIV;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              en    = 1'b0;
    logic              mute  = 1'b0;
    logic [DATA_W-1:0] left_in  = '0;
    logic [DATA_W-1:0] right_in = '0;
    logic              sclk;
    logic              lrclk;
    logic              sdata;
    logic              valid;

    codec_i2s_tx #(.SCLK_DIV(SCLK_DIV), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mute     (mute),
        .left_in  (left_in),
        .right_in (right_in),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              ch;
        logic [DATA_W-1:0] word;
    } slot_t;

    slot_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        exp_q.push_back({1'b0, l});
        exp_q.push_back({1'b1, r});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sclk"},  sclk,  32'd0);
        check({tag, "_lrclk"}, lrclk, 32'd0);
        check({tag, "_sdata"}, sdata, 32'd0);
        check({tag, "_valid"}, valid, 32'd0);
    endtask

    // Monitor state
    logic              en_seen    = 1'b0;
    logic              prev_sclk  = 1'b0;
    logic              prev_lr    = 1'b0;
    logic              prev_valid = 1'b0;
    logic              run        = 1'b0;
    logic              pad_bad    = 1'b0;
    logic              have_valid = 1'b0;
    int                pos        = 0;
    int                since_valid = 0;
    int                valid_cnt  = 0;
    int                fall_cnt   = 0;
    logic [DATA_W-1:0] word       = '0;
    slot_t             got;

    always @(posedge clk) en_seen <= en;

    // Deserialize on sclk falls and check each completed slot against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n || !en_seen) begin
            run        = 1'b0;
            have_valid = 1'b0;
            prev_sclk  = 1'b0;
        end else begin
            since_valid++;
            if (valid) begin
                valid_cnt++;
                check("valid_on_lr_rise", {30'd0, prev_lr, lrclk}, 32'd1);
                check("valid_width", prev_valid, 32'd0);
                if (have_valid) check("valid_period", since_valid, FRAME_CLKS);
                have_valid  = 1'b1;
                since_valid = 0;
            end
            if (prev_sclk && !sclk) begin
                fall_cnt++;
                if (!run || (lrclk != prev_lr)) begin
                    run = 1'b1; pos = 0; word = '0; pad_bad = 1'b0;
                end else begin
                    pos++;
                end
                if (pos >= 1 && pos <= DATA_W) word[DATA_W-pos] = sdata;
                else if (sdata) pad_bad = 1'b1;
                if (pos == SLOT_W - 1) begin
                    check("pad_zero", pad_bad, 32'd0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_empty: got slot word %0h expected no slot", word);
                    end else begin
                        got = exp_q.pop_front();
                        check(lrclk ? "right_word" : "left_word", word, got.word);
                        check("slot_channel", lrclk, got.ch);
                    end
                end
            end
            prev_sclk = sclk;
        end
        prev_lr    = lrclk;
        prev_valid = valid;
    end

    int   first_fall;
    logic saw_hi;
    int   falls_snap;
    int   valids_snap;

    initial begin
        #1 rst_n = 1'b0;
        #2 check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(3);
        check_idle("idle_en0");

        // Frames 0..2: basic pattern, mid-frame input change, mid-frame mute
        left_in  = 16'hA5C3;
        right_in = 16'h1234;
        push_frame(16'hA5C3, 16'h1234);
        push_frame(16'hFFFF, 16'h1234);
        push_frame(16'h0000, 16'h0000);
        en = 1'b1;
        wait_clks(24);
        left_in = 16'hFFFF;
        wait_clks(300);
        mute    = 1'b1;
        left_in = 16'h7FFF;
        wait_clks(256);
        mute     = 1'b0;
        left_in  = 16'h8000;
        right_in = 16'hFFFF;
        wait_clks(272);
        en = 1'b0;
        @(negedge clk);
        check_idle("abort");
        check("queue_drained_1", exp_q.size(), 32'd0);

        // Short en pulse must not start a frame
        falls_snap  = fall_cnt;
        valids_snap = valid_cnt;
        en = 1'b1;
        wait_clks(3);
        en = 1'b0;
        wait_clks(20);
        check("short_en_falls", fall_cnt, falls_snap);
        check("short_en_valids", valid_cnt, valids_snap);

        // Re-enable: first fall after 2*SCLK_DIV clks, fresh samples latched
        left_in  = 16'h0F0F;
        right_in = 16'hC001;
        push_frame(16'h0F0F, 16'hC001);
        en = 1'b1;
        saw_hi     = 1'b0;
        first_fall = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sclk) saw_hi = 1'b1;
            else if (saw_hi) begin
                first_fall = i;
                break;
            end
        end
        check("first_fall_clks", first_fall, 2 * SCLK_DIV);

        // Async reset mid-slot of the following frame, then boundary values after release
        wait_clks(296);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        left_in  = 16'h8000;
        right_in = 16'hFFFF;
        push_frame(16'h8000, 16'hFFFF);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_clks(280);
        en = 1'b0;
        wait_clks(4);
        check("queue_drained_2", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
